// File: rtl/qbert_jump_ctrl_pkg.sv
// Shared Q*bert types and default pyramid geometry, also used by the renderer and the pyramid drawer.
package qbert_pkg;

   typedef enum logic [1:0] {UP_LEFT, UP_RIGHT, DOWN_LEFT, DOWN_RIGHT} dir_t;
   typedef enum logic [1:0] {IDLE, LIFT, SLIDE, DROP} jump_state_t;

   localparam int unsigned QB_ROWS     = 7;
   localparam logic [10:0] QB_X_ORG    = 11'd400;
   localparam logic [9:0]  QB_Y_ORG    = 10'd100;
   localparam logic [10:0] QB_CUBE_HW  = 11'd30;
   localparam logic [9:0]  QB_CUBE_H   = 10'd50;
   localparam logic [9:0]  QB_LIFT_H   = 10'd10;
   localparam int unsigned QB_MOVE_DIV = 500000;

endpackage

// File: rtl/qbert_jump_ctrl_if.sv
// Command/status bundle between the game controller (master) and the jump controller (slave).
interface qbert_jump_ctrl_if;
   import qbert_pkg::*;

   logic        qbert_jump;
   dir_t        jump_dir;
   logic        restart;
   logic [10:0] qbert_x;
   logic [9:0]  qbert_y;
   logic [2:0]  qbert_row;
   logic [2:0]  qbert_col;
   logic        busy;
   logic        jump_done;
   logic        jump_err;

   modport master (
      output qbert_jump, jump_dir, restart,
      input  qbert_x, qbert_y, qbert_row, qbert_col, busy, jump_done, jump_err
   );

   modport slave (
      input  qbert_jump, jump_dir, restart,
      output qbert_x, qbert_y, qbert_row, qbert_col, busy, jump_done, jump_err
   );

endinterface

// File: rtl/qbert_jump_ctrl_tick_prescaler.sv
// Free-running motion prescaler; tick is high for one cycle every MOVE_DIV cycles after clr drops.
module tick_prescaler #(
   parameter int unsigned MOVE_DIV = 500000
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (clr || (r_cnt == LAST))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert cube tracker: validates diagonal hops and animates lift/slide/drop in sprite-origin pixels.
module qbert_jump_ctrl
   import qbert_pkg::*;
#(
   parameter int unsigned ROWS     = QB_ROWS,
   parameter logic [10:0] X_ORG    = QB_X_ORG,
   parameter logic [9:0]  Y_ORG    = QB_Y_ORG,
   parameter logic [10:0] CUBE_HW  = QB_CUBE_HW,
   parameter logic [9:0]  CUBE_H   = QB_CUBE_H,
   parameter logic [9:0]  LIFT_H   = QB_LIFT_H,
   parameter int unsigned MOVE_DIV = QB_MOVE_DIV
)(
   input  logic              clk,
   input  logic              reset,
   qbert_jump_ctrl_if.slave  bus
);

   localparam logic signed [4:0] ROWS_S = 5'(ROWS);

   function automatic logic [10:0] f_px_x(input logic [2:0] row, input logic [2:0] col);
      f_px_x = X_ORG - 11'(row) * CUBE_HW + 11'(col) * (CUBE_HW << 1);
   endfunction

   function automatic logic [9:0] f_px_y(input logic [2:0] row);
      f_px_y = Y_ORG + 10'(row) * CUBE_H;
   endfunction

   jump_state_t       r_state, w_state_nxt;
   logic [2:0]        r_row, r_col, r_trow, r_tcol;
   logic [10:0]       r_x, r_xt;
   logic [9:0]        r_y, r_yt, r_ylift, r_yslide;
   logic              r_busy, r_done, r_err;

   logic [2:0]        w_row_nxt, w_col_nxt, w_trow_nxt, w_tcol_nxt;
   logic [10:0]       w_x_nxt, w_xt_nxt;
   logic [9:0]        w_y_nxt, w_yt_nxt, w_ylift_nxt, w_yslide_nxt;
   logic              w_busy_nxt, w_done_nxt, w_err_nxt;

   logic              w_tick, w_clr, w_valid, w_accept;
   logic signed [4:0] w_row_s, w_col_s, w_trow_s, w_tcol_s;
   logic [2:0]        w_trow, w_tcol;
   logic [10:0]       w_xs;
   logic [9:0]        w_ys;

   // Prescaler is held cleared while idle so the first tick of a hop lands MOVE_DIV cycles in.
   assign w_clr = (r_state == IDLE) || bus.restart;

   tick_prescaler #(.MOVE_DIV(MOVE_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   assign w_row_s = $signed({2'b00, r_row});
   assign w_col_s = $signed({2'b00, r_col});

   always_comb begin
      w_trow_s = w_row_s;
      w_tcol_s = w_col_s;
      case (bus.jump_dir)
         UP_LEFT:    begin w_trow_s = w_row_s - 5'sd1; w_tcol_s = w_col_s - 5'sd1; end
         UP_RIGHT:   begin w_trow_s = w_row_s - 5'sd1; w_tcol_s = w_col_s;         end
         DOWN_LEFT:  begin w_trow_s = w_row_s + 5'sd1; w_tcol_s = w_col_s;         end
         DOWN_RIGHT: begin w_trow_s = w_row_s + 5'sd1; w_tcol_s = w_col_s + 5'sd1; end
         default:    begin w_trow_s = w_row_s;         w_tcol_s = w_col_s;         end
      endcase
   end

   assign w_valid  = (w_trow_s >= 5'sd0) && (w_trow_s < ROWS_S) &&
                     (w_tcol_s >= 5'sd0) && (w_tcol_s <= w_trow_s);
   assign w_trow   = w_trow_s[2:0];
   assign w_tcol   = w_tcol_s[2:0];
   assign w_accept = (r_state == IDLE) && bus.qbert_jump && w_valid && !bus.restart;

   // x and y walk independently toward the lifted target during SLIDE.
   assign w_xs = (r_x < r_xt) ? r_x + 11'd1 : ((r_x > r_xt) ? r_x - 11'd1 : r_x);
   assign w_ys = (r_y < r_yslide) ? r_y + 10'd1 : ((r_y > r_yslide) ? r_y - 10'd1 : r_y);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.restart)
         w_state_nxt = IDLE;
      else begin
         case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LIFT;
            LIFT:    if (w_tick && (r_y - 10'd1 == r_ylift)) w_state_nxt = SLIDE;
            SLIDE:   if (w_tick && (w_xs == r_xt) && (w_ys == r_yslide)) w_state_nxt = DROP;
            DROP:    if (w_tick && (r_y + 10'd1 == r_yt)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_row_nxt    = r_row;
      w_col_nxt    = r_col;
      w_trow_nxt   = r_trow;
      w_tcol_nxt   = r_tcol;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_xt_nxt     = r_xt;
      w_yt_nxt     = r_yt;
      w_ylift_nxt  = r_ylift;
      w_yslide_nxt = r_yslide;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      if (bus.restart) begin
         w_row_nxt  = 3'd0;
         w_col_nxt  = 3'd0;
         w_x_nxt    = X_ORG;
         w_y_nxt    = Y_ORG;
         w_busy_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_trow_nxt   = w_trow;
                  w_tcol_nxt   = w_tcol;
                  w_xt_nxt     = f_px_x(w_trow, w_tcol);
                  w_yt_nxt     = f_px_y(w_trow);
                  w_ylift_nxt  = r_y - LIFT_H;
                  w_yslide_nxt = f_px_y(w_trow) - LIFT_H;
                  w_busy_nxt   = 1'b1;
               end else if (bus.qbert_jump) begin
                  w_err_nxt = 1'b1;
               end
            end
            LIFT: begin
               if (w_tick) w_y_nxt = r_y - 10'd1;
            end
            SLIDE: begin
               if (w_tick) begin
                  w_x_nxt = w_xs;
                  w_y_nxt = w_ys;
               end
            end
            DROP: begin
               if (w_tick) begin
                  w_y_nxt = r_y + 10'd1;
                  if (r_y + 10'd1 == r_yt) begin
                     w_row_nxt  = r_trow;
                     w_col_nxt  = r_tcol;
                     w_busy_nxt = 1'b0;
                     w_done_nxt = 1'b1;
                  end
               end
            end
            default: w_busy_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row    <= 3'd0;
         r_col    <= 3'd0;
         r_trow   <= 3'd0;
         r_tcol   <= 3'd0;
         r_x      <= X_ORG;
         r_y      <= Y_ORG;
         r_xt     <= X_ORG;
         r_yt     <= Y_ORG;
         r_ylift  <= Y_ORG;
         r_yslide <= Y_ORG;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_row    <= w_row_nxt;
         r_col    <= w_col_nxt;
         r_trow   <= w_trow_nxt;
         r_tcol   <= w_tcol_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_xt     <= w_xt_nxt;
         r_yt     <= w_yt_nxt;
         r_ylift  <= w_ylift_nxt;
         r_yslide <= w_yslide_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign bus.qbert_x   = r_x;
   assign bus.qbert_y   = r_y;
   assign bus.qbert_row = r_row;
   assign bus.qbert_col = r_col;
   assign bus.busy      = r_busy;
   assign bus.jump_done = r_done;
   assign bus.jump_err  = r_err;

endmodule
